// File: rtl/rr_mux8_sched.sv
// Round-robin scheduler for a shared 8:1 datapath mux: owns the mux select and
// one-hot grant, steers the granted requester's data onto one valid/ready port.
module rr_mux8_sched #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            req,
  input  logic [8*DATA_W-1:0]   din,
  input  logic                  out_ready,
  output logic [2:0]            sel,
  output logic [7:0]            gnt,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     dout,
  output logic                  busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  sel_reg, sel_next;
  logic [2:0]  ptr_reg, ptr_next;
  logic [7:0]  gnt_reg, gnt_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic [DATA_W-1:0] din_arr [8];
  logic [3:0]        pick;
  logic [7:0]        pick_onehot;
  logic [2:0]        arb_base;
  logic              beat;
  logic              last_beat;
  logic              release_now;

  // Returns {found, index}; scanning from lowest to highest priority lets the
  // last hit (closest after the base) win.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 8; k >= 1; k--) begin
      idx = base + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign din_arr[gi]     = din[gi*DATA_W +: DATA_W];
      assign pick_onehot[gi] = pick[3] && (pick[2:0] == 3'(gi));
    end
  endgenerate

  assign busy      = (state_reg == GRANT);
  assign sel       = sel_reg;
  assign gnt       = gnt_reg;
  assign out_valid = busy && req[sel_reg];
  assign dout      = din_arr[sel_reg];

  // On release the pointer moves to the current owner, so arbitrate from sel.
  assign arb_base    = busy ? sel_reg : ptr_reg;
  assign pick        = rr_pick(req, arb_base);
  assign beat        = out_valid && out_ready;
  assign last_beat   = beat && (cnt_reg == 4'(MAX_HOLD - 1));
  assign release_now = busy && (!req[sel_reg] || last_beat);

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick[3]) begin
          state_next = GRANT;
          sel_next   = pick[2:0];
          gnt_next   = pick_onehot;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_next = sel_reg;
          cnt_next = '0;
          if (pick[3]) begin
            sel_next = pick[2:0];
            gnt_next = pick_onehot;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (beat) begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      ptr_reg   <= 3'd7;
      gnt_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: doc/rr_mux8_sched.md
Name: rr_mux8_sched

Overview:
- Round-robin scheduler that shares one 8:1 datapath mux between 8 requesters.
- Owns the 3-bit mux select and one-hot grant, and steers the granted requester's data to a single valid/ready output port.
- Caps consecutive beats per grant so no requester can starve the others.
- Sits in front of the 8:1 mux tree; the select it drives is the mux's s[2:0].

Parameters:
DATA_W, 8, width of each requester's data word
MAX_HOLD, 4, max beats transferred per grant before forced re-arbitration (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  8  per-requester request; must stay high while the requester has data
din  input  8*DATA_W  packed requester data, requester k at din[k*DATA_W +: DATA_W]
out_ready  input  1  downstream accepts a beat this cycle
sel  output  3  mux select, index of the granted requester (registered)
gnt  output  8  one-hot grant (registered); all zero when idle
out_valid  output  1  beat offered downstream
dout  output  DATA_W  selected data word
busy  output  1  high while in GRANT state

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sel=0, gnt=0, out_valid=0, busy=0.
  - Beat counter cnt=0; round-robin pointer ptr=7, so requester 0 has first priority.
- Arbitration function: the winner is the first requester with req=1, searching ptr+1, ptr+2, ... ptr+8, modulo 8. The requester at ptr is lowest priority.
- State IDLE:
  - gnt=0, out_valid=0.
  - If req!=0, next clock: state=GRANT, sel=winner, gnt=1<<winner, cnt=0.
  - Latency from req rising to gnt/out_valid is 1 cycle.
- State GRANT:
  - out_valid = req[sel] (combinational).
  - dout = din[sel*DATA_W +: DATA_W] (combinational, regardless of out_valid).
  - A beat transfers on a clock edge where out_valid & out_ready; then cnt increments.
- Release conditions, evaluated every GRANT cycle:
  - (a) req[sel]=0.
  - (b) A beat transfers and cnt==MAX_HOLD-1.
- On release:
  - ptr=sel.
  - Re-arbitrate in the same cycle over current req (req[sel] included, lowest priority).
  - If the result is non-zero: stay in GRANT with new sel/gnt and cnt=0, giving back-to-back grants with no bubble.
  - Otherwise: go to IDLE with gnt=0.
- No release without (a) or (b): sel/gnt hold; out_ready low stalls indefinitely with the grant held.
- Sole requester after MAX_HOLD: it is re-granted, sel unchanged, cnt reset to 0; out_valid stays high continuously.
- Requests from non-granted requesters never affect out_valid or dout.
- Simultaneous events:
  - Request drop and last beat in the same cycle release once; no extra beat is counted.
  - A new req arriving on a release cycle participates in that arbitration.
- Reset mid-transfer forces all outputs to reset values immediately; any in-flight beat is not transferred.
- gnt is always one-hot or zero; sel always matches the gnt index whenever busy=1.

Test Plan:
1. Reset release, req=8'h01, out_ready=1, din[0]=8'hA5 -> cycle+1: gnt=01, sel=0, out_valid=1, dout=A5; release after 4 beats, then re-granted to 0 (sole requester).
2. req=8'hFF constant, out_ready=1 -> grants in order 0,1,...,7,0, each exactly 4 beats, no idle cycles between grants.
3. Grant to 2 with out_ready=0 for 10 cycles, req=8'h0C -> sel stays 2, out_valid=1, cnt unchanged; after out_ready rises, 4 beats, then gnt=08.
4. Granted 5 drops req after 1 beat while req[6]=1 -> same cycle release, next cycle gnt=40, sel=6, cnt=0.
5. req=8'h81 with ptr=0 after a grant to 0 -> next winner 7, then 0.
6. Assert rst during GRANT with out_valid=1 -> gnt=0, sel=0, out_valid=0, busy=0 immediately; after reset, req=8'h80 gives gnt=80.
